// File: rtl/kmap_sweep_ctrl.sv
// Sweep sequencer for a 4-input K-map block: drives all 16 input vectors,
// captures the block's output after a settle interval, and checks the
// captured truth table against an expected mask with don't-care bits.
`timescale 1ns/1ps
module kmap_sweep_ctrl #(
  // Cycles each vector is held before sampling; legal range 1..255
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] exp_mask,
  input  logic [15:0] dc_mask,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        k_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] truth_table,
  output logic [15:0] err_mask,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err_idx,
  output logic        first_err_valid
);

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_t;

  state_t      state;
  logic [3:0]  idx;
  logic [7:0]  settle_cnt;
  logic [15:0] exp_q;
  logic [15:0] dc_q;
  logic        mis;

  // Current sample disagrees with the latched expectation and is not masked
  always_comb begin
    mis = (k_in != exp_q[idx]) && !dc_q[idx];
  end

  // Sweep FSM; every output is a register updated here
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= StIdle;
      idx             <= 4'h0;
      settle_cnt      <= 8'h0;
      exp_q           <= 16'h0;
      dc_q            <= 16'h0;
      {a, b, c, d}    <= 4'h0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      truth_table     <= 16'h0;
      err_mask        <= 16'h0;
      err_count       <= 5'h0;
      first_err_idx   <= 4'h0;
      first_err_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          {a, b, c, d} <= 4'h0;
          busy         <= 1'b0;
          // abort has priority over start while idle
          if (start && !abort) begin
            exp_q           <= exp_mask;
            dc_q            <= dc_mask;
            truth_table     <= 16'h0;
            err_mask        <= 16'h0;
            err_count       <= 5'h0;
            first_err_idx   <= 4'h0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
            idx             <= 4'h0;
            settle_cnt      <= 8'h0;
            busy            <= 1'b1;
            state           <= StSettle;
          end
        end

        StSettle: begin
          if (abort) begin
            state        <= StIdle;
            busy         <= 1'b0;
            pass         <= 1'b0;
            {a, b, c, d} <= 4'h0;
          end else if (settle_cnt == SettleLast) begin
            state <= StSample;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end

        StSample: begin
          if (abort) begin
            // capture suppressed; partial results are kept
            state        <= StIdle;
            busy         <= 1'b0;
            pass         <= 1'b0;
            {a, b, c, d} <= 4'h0;
          end else begin
            truth_table[idx] <= k_in;
            if (mis) begin
              err_mask[idx] <= 1'b1;
              err_count     <= err_count + 5'd1;
              if (!first_err_valid) begin
                first_err_idx   <= idx;
                first_err_valid <= 1'b1;
              end
            end
            if (idx == 4'hF) begin
              state        <= StDone;
              done         <= 1'b1;
              // include the final capture, which lands on this same edge
              pass         <= (err_mask == 16'h0) && !mis;
              busy         <= 1'b0;
              {a, b, c, d} <= 4'h0;
            end else begin
              idx          <= idx + 4'd1;
              settle_cnt   <= 8'h0;
              {a, b, c, d} <= idx + 4'd1;
              state        <= StSettle;
            end
          end
        end

        StDone: begin
          // abort and start are both ignored here
          state <= StIdle;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// Self-checking bench for kmap_sweep_ctrl: expected sweep results are queued
// when a sweep is started and popped when the done pulse appears.
`timescale 1ns/1ps
module tb_kmap_sweep_ctrl;

  typedef struct packed {
    logic [15:0] tt;
    logic [15:0] em;
    logic [4:0]  ec;
    logic [3:0]  fi;
    logic        fv;
    logic        ps;
  } res_t;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [15:0] exp_mask, dc_mask;
  logic a, b, c, d, k_in, busy, done, pass, first_err_valid;
  logic [15:0] truth_table, err_mask;
  logic [4:0]  err_count;
  logic [3:0]  first_err_idx;
  int kmode;

  // second instance built with the minimum settle interval
  logic start1;
  logic [15:0] exp1;
  logic a1, b1, c1, d1, busy1, done1, pass1, fev1;
  logic [15:0] tt1, em1;
  logic [4:0]  ec1;
  logic [3:0]  fi1;

  int total = 0;
  int bad   = 0;
  res_t sb[$];
  res_t obs;

  always #5 clk = ~clk;

  // Kmap stand-ins: 0 -> f=d, 1 -> f=~d, 2 -> f=a^b^c^d
  assign k_in = (kmode == 0) ? d : (kmode == 1) ? ~d : (a ^ b ^ c ^ d);
  assign obs  = {truth_table, err_mask, err_count, first_err_idx, first_err_valid, pass};

  kmap_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .exp_mask(exp_mask), .dc_mask(dc_mask),
    .a(a), .b(b), .c(c), .d(d), .k_in(k_in),
    .busy(busy), .done(done), .pass(pass),
    .truth_table(truth_table), .err_mask(err_mask), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_valid(first_err_valid)
  );

  kmap_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
    .exp_mask(exp1), .dc_mask(16'h0),
    .a(a1), .b(b1), .c(c1), .d(d1), .k_in(d1),
    .busy(busy1), .done(done1), .pass(pass1),
    .truth_table(tt1), .err_mask(em1), .err_count(ec1),
    .first_err_idx(fi1), .first_err_valid(fev1)
  );

  function automatic res_t model(input logic [15:0] e, input logic [15:0] dcm, input int mode);
    res_t r;
    logic [3:0] iv;
    logic kv;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      kv = (mode == 0) ? iv[0] : (mode == 1) ? ~iv[0] : ^iv;
      r.tt[i] = kv;
      if (kv != e[i] && !dcm[i]) begin
        r.em[i] = 1'b1;
        r.ec    = r.ec + 5'd1;
        if (!r.fv) begin
          r.fi = iv;
          r.fv = 1'b1;
        end
      end
    end
    r.ps = (r.em == 16'h0);
    return r;
  endfunction

  // Start a sweep; returns at the negedge after the start edge
  task automatic kick(input logic [15:0] e, input logic [15:0] dcm, input int mode,
                      input bit push);
    @(negedge clk);
    exp_mask = e;
    dc_mask  = dcm;
    kmode    = mode;
    start    = 1'b1;
    if (push) sb.push_back(model(e, dcm, mode));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count negedges until done is seen (bounded)
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 300);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({a, b, c, d, busy, done, obs} !== '0) begin
      bad++;
      $display("FAIL reset_state: got %h want 0", {a, b, c, d, busy, done, obs});
    end
    rst = 1'b0;
  endtask

  task automatic test_match();
    int n;
    res_t e;
    kick(16'hAAAA, 16'h0, 0, 1'b1);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b want 1", busy); end
    wait_done(n);
    total++;
    if (n != 80) begin bad++; $display("FAIL match_latency: got %0d want 80", n); end
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL match_result: got %h want %h", obs, e); end
    @(negedge clk);
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++;
      $display("FAIL done_one_cycle: got done/busy %b want 00", {done, busy});
    end
  endtask

  task automatic test_single_error();
    int n;
    res_t e;
    kick(16'hAAAB, 16'h0, 0, 1'b1);
    wait_done(n);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL single_error: got %h want %h", obs, e); end
  endtask

  task automatic test_dont_care_latch();
    int n;
    res_t e;
    kick(16'hAAAB, 16'h0001, 0, 1'b1);
    repeat (20) @(negedge clk);
    exp_mask = 16'h0000;
    dc_mask  = 16'h0000;
    wait_done(n);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL dont_care_latched: got %h want %h", obs, e); end
  endtask

  task automatic test_all_wrong();
    int n;
    res_t e;
    kick(16'hAAAA, 16'h0, 1, 1'b1);
    wait_done(n);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL all_wrong: got %h want %h", obs, e); end
  endtask

  task automatic test_random_parity();
    int n;
    res_t e;
    for (int k = 0; k < 3; k++) begin
      kick(16'($urandom), 16'($urandom) & 16'($urandom), 2, 1'b1);
      wait_done(n);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL parity_%0d: got %h want %h", k, obs, e); end
    end
  endtask

  task automatic test_abort();
    int n;
    int dones;
    res_t e;
    kick(16'hAAAA, 16'h0, 0, 1'b0);
    n = 0;
    while ({a, b, c, d} != 4'd7 && n < 100) begin @(negedge clk); n++; end
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({busy, done, pass, a, b, c, d} !== 7'b0) begin
      bad++;
      $display("FAIL abort_outputs: got %b want 0", {busy, done, pass, a, b, c, d});
    end
    total++;
    if (truth_table !== 16'h002A) begin
      bad++;
      $display("FAIL abort_partial_table: got %h want 002a", truth_table);
    end
    dones = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) dones++;
    end
    total++;
    if (dones != 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", dones); end
    kick(16'hAAAA, 16'h0, 0, 1'b1);
    wait_done(n);
    e = sb.pop_front();
    total++;
    if (n != 80 || obs !== e) begin
      bad++;
      $display("FAIL restart_after_abort: got %0d/%h want 80/%h", n, obs, e);
    end
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_beats_start: busy %b want 0", busy); end
  endtask

  task automatic test_settle_one();
    int n;
    @(negedge clk);
    exp1   = 16'hAAAA;
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!done1 && n < 100);
    total++;
    if (n != 32) begin bad++; $display("FAIL settle1_latency: got %0d want 32", n); end
    total++;
    if ({tt1, em1, pass1} !== {16'hAAAA, 16'h0, 1'b1}) begin
      bad++;
      $display("FAIL settle1_result: got %h/%h/%b want aaaa/0000/1", tt1, em1, pass1);
    end
  endtask

  task automatic test_reset_back_to_back();
    int n;
    res_t e;
    kick(16'hAAAB, 16'h0, 0, 1'b0);
    n = 0;
    while ({a, b, c, d} != 4'd10 && n < 100) begin @(negedge clk); n++; end
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({a, b, c, d, busy, done, obs} !== '0) begin
      bad++;
      $display("FAIL midsweep_reset: got %h want 0", {a, b, c, d, busy, done, obs});
    end
    exp_mask = 16'hAAAA;
    dc_mask  = 16'h0;
    sb.push_back(model(16'hAAAA, 16'h0, 0));
    sb.push_back(model(16'hAAAA, 16'h0, 0));
    rst = 1'b0;
    wait_done(n);
    e = sb.pop_front();
    total++;
    if (n != 81 || obs !== e) begin
      bad++;
      $display("FAIL b2b_first: got %0d/%h want 81/%h", n, obs, e);
    end
    wait_done(n);
    start = 1'b0;
    e = sb.pop_front();
    total++;
    if (n != 82 || obs !== e) begin
      bad++;
      $display("FAIL b2b_second: got %0d/%h want 82/%h", n, obs, e);
    end
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_stops: busy %b want 0", busy); end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    start1   = 1'b0;
    exp1     = 16'h0;
    exp_mask = 16'h0;
    dc_mask  = 16'h0;
    kmode    = 0;
    test_reset();
    test_match();
    test_single_error();
    test_dont_care_latch();
    test_all_wrong();
    test_random_parity();
    test_abort();
    test_start_abort_idle();
    test_settle_one();
    test_reset_back_to_back();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drained: got %0d left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
